// File: rtl/int_pipe_ctrl_pkg.sv
// int_pipe_ctrl_pkg
//   Shared types and helpers for the pipeline sequencing controller.
//   - state_t         : interrupt sequencing FSM encoding
//   - NUM_IRQ_DEF     : default number of interrupt sources
//   - REGW_DEF        : default register-number width
//   - priority_encode : keeps only the highest set bit (one-hot result)
package int_pipe_ctrl_pkg;

  localparam int NUM_IRQ_DEF = 3;
  localparam int REGW_DEF    = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_ISR   = 2'd2
  } state_t;

  // Operates on a 32-bit container; callers size-cast in and out.
  function automatic logic [31:0] priority_encode(input logic [31:0] req);
    logic [31:0] res;
    res = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i] && (res == '0)) res[i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/int_pipe_ctrl_if.sv
// int_pipe_ctrl_if
//   Bundles the pipeline status inputs and the control outputs of
//   int_pipe_ctrl.
//   master : pipeline / environment side (drives status, receives controls)
//   slave  : controller side
//   Inputs to the controller : hold, ex_memtoreg, ex_rd, id_rs1, id_rs2,
//                              id_r1_used, id_r2_used, br_taken, uret_ex,
//                              ie, irq
//   Outputs of the controller: pc_en, ifid_en, idex_en, ifid_flush,
//                              idex_flush, int_enter, irs, int_busy
interface int_pipe_ctrl_if #(
  parameter int NUM_IRQ = 3,
  parameter int REGW    = 5
);
  logic               hold;
  logic               ex_memtoreg;
  logic [REGW-1:0]    ex_rd;
  logic [REGW-1:0]    id_rs1;
  logic [REGW-1:0]    id_rs2;
  logic               id_r1_used;
  logic               id_r2_used;
  logic               br_taken;
  logic               uret_ex;
  logic               ie;
  logic [NUM_IRQ-1:0] irq;

  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               ifid_flush;
  logic               idex_flush;
  logic               int_enter;
  logic [NUM_IRQ-1:0] irs;
  logic               int_busy;

  modport master (
    output hold, ex_memtoreg, ex_rd, id_rs1, id_rs2, id_r1_used, id_r2_used,
           br_taken, uret_ex, ie, irq,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, int_enter, irs,
           int_busy
  );

  modport slave (
    input  hold, ex_memtoreg, ex_rd, id_rs1, id_rs2, id_r1_used, id_r2_used,
           br_taken, uret_ex, ie, irq,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, int_enter, irs,
           int_busy
  );
endinterface

// File: rtl/int_pipe_ctrl_hazard_detect.sv
// int_pipe_ctrl_hazard_detect
//   Combinational load-use detector: the EX instruction is a load whose
//   destination (non-zero) is read by the ID instruction.
//   ex_memtoreg, ex_rd        : EX-stage load flag and destination
//   id_rs1/2, id_r1/2_used    : ID-stage sources and whether they are read
//   load_use                  : stall request
module int_pipe_ctrl_hazard_detect #(
  parameter int REGW = 5
) (
  input  logic            ex_memtoreg,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_r1_used,
  input  logic            id_r2_used,
  output logic            load_use
);

  assign load_use = ex_memtoreg && (ex_rd != '0) &&
                    ((id_r1_used && (ex_rd == id_rs1)) ||
                     (id_r2_used && (ex_rd == id_rs2)));

endmodule

// File: rtl/int_pipe_ctrl.sv
// int_pipe_ctrl
//   Pipeline sequencing controller for the 5-stage interrupt-capable core.
//   Generates PC / IF-ID / ID-EX enables and flushes (load-use stall,
//   taken-branch flush, global hold), latches and prioritises interrupt
//   requests, issues the one-cycle int_enter bubble and tracks the handler.
//   Ports:
//     clk  : clock
//     rst  : synchronous reset, active-low
//     bus  : int_pipe_ctrl_if.slave (pipeline status in, controls out)
//   Build option: INT_NESTED_EN enables nested interrupts (higher-index
//   source may pre-empt a running handler).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal execution, waiting for an enabled pending request
//   ST_ENTER | replace the ID instruction with the entry bubble (retries
//            | while the ID slot is wrong-path or frozen)
//   ST_ISR   | handler running until uret reaches EX
module int_pipe_ctrl
  import int_pipe_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int REGW    = REGW_DEF
) (
  input logic           clk,
  input logic           rst,
  int_pipe_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] sel_q, sel_d;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] ack;
  logic               load_use;
  logic               lu_eff;

  logic pc_en_c, ifid_en_c, idex_en_c, ifid_flush_c, idex_flush_c;
  logic int_enter_c;

`ifdef INT_NESTED_EN
  logic [NUM_IRQ-1:0] hi_srv;
  logic [NUM_IRQ-1:0] above;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] remain;
`endif

  int_pipe_ctrl_hazard_detect #(.REGW(REGW)) u_hazard (
    .ex_memtoreg (bus.ex_memtoreg),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_r1_used  (bus.id_r1_used),
    .id_r2_used  (bus.id_r2_used),
    .load_use    (load_use)
  );

  // The ID instruction is discarded in ENTER, so its hazard is irrelevant.
  assign lu_eff = load_use && (state_q != ST_ENTER);

`ifdef INT_NESTED_EN
  assign hi_srv   = NUM_IRQ'(priority_encode(32'(in_service_q)));
  assign above    = (hi_srv == '0) ? '1 : ~(hi_srv | (hi_srv - NUM_IRQ'(1)));
  assign eligible = pending_q & above;
  assign remain   = in_service_q & ~hi_srv;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    in_service_d = in_service_q;
    ack          = '0;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    int_enter_c  = 1'b0;

    if (bus.hold) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      idex_en_c = 1'b0;
    end else begin
      // Redirect beats stall: the stalled instruction is wrong-path anyway.
      if (bus.br_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (lu_eff) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end

      unique case (state_q)
        ST_RUN: begin
          if (bus.ie && (|pending_q) && !bus.br_taken) begin
            sel_d   = NUM_IRQ'(priority_encode(32'(pending_q)));
            ack     = sel_d;
            state_d = ST_ENTER;
          end
        end
        ST_ENTER: begin
          if (!bus.br_taken) begin
            int_enter_c  = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b0;
            in_service_d = in_service_q | sel_q;
            state_d      = ST_ISR;
          end
        end
        ST_ISR: begin
`ifdef INT_NESTED_EN
          if (bus.uret_ex) begin
            in_service_d = remain;
            if (remain == '0) begin
              sel_d   = '0;
              state_d = ST_RUN;
            end else begin
              sel_d = NUM_IRQ'(priority_encode(32'(remain)));
            end
          end else if (bus.ie && (|eligible) && !bus.br_taken) begin
            sel_d   = NUM_IRQ'(priority_encode(32'(eligible)));
            ack     = sel_d;
            state_d = ST_ENTER;
          end
`else
          if (bus.uret_ex) begin
            in_service_d = '0;
            sel_d        = '0;
            state_d      = ST_RUN;
          end
`endif
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      sel_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      in_service_q <= in_service_d;
      // New request on a bit wins over its acknowledge.
      pending_q    <= (pending_q & ~ack) | bus.irq;
    end
  end

  // Outputs are forced to pass-through values for as long as rst is low.
  assign bus.pc_en      = !rst || pc_en_c;
  assign bus.ifid_en    = !rst || ifid_en_c;
  assign bus.idex_en    = !rst || idex_en_c;
  assign bus.ifid_flush = rst && ifid_flush_c;
  assign bus.idex_flush = rst && idex_flush_c;
  assign bus.int_enter  = rst && int_enter_c;
  assign bus.irs        = (rst && (state_q == ST_ISR)) ? sel_q : '0;
  assign bus.int_busy   = rst && ((state_q == ST_ISR) || (|in_service_q));

endmodule

// File: tb/tb_int_pipe_ctrl.sv
module tb_int_pipe_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int_pipe_ctrl_if #(.NUM_IRQ(3), .REGW(5)) bus ();

  int_pipe_ctrl #(.NUM_IRQ(3), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.hold        = 1'b0;
    bus.ex_memtoreg = 1'b0;
    bus.ex_rd       = '0;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_r1_used  = 1'b0;
    bus.id_r2_used  = 1'b0;
    bus.br_taken    = 1'b0;
    bus.uret_ex     = 1'b0;
    bus.irq         = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_inputs();
    bus.ie = 1'b0;
    rst    = 1'b0;

    // Reset: outputs pass-through even with hazard/branch inputs active
    tick();
    bus.ex_memtoreg = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    bus.id_r1_used = 1'b1; bus.br_taken = 1'b1;
    #1;
    check("rst_pc_en", bus.pc_en, 1);
    check("rst_ifid_en", bus.ifid_en, 1);
    check("rst_ifid_flush", bus.ifid_flush, 0);
    check("rst_idex_flush", bus.idex_flush, 0);
    check("rst_int_busy", bus.int_busy, 0);
    check("rst_irs", bus.irs, 0);
    clr_inputs();
    tick();
    rst = 1'b1;
    tick();

    // 1. Load-use stall, then ex_rd=0 and unused rs2 produce no stall
    bus.ex_memtoreg = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    bus.id_r1_used = 1'b1;
    #1;
    check("lu_pc_en", bus.pc_en, 0);
    check("lu_ifid_en", bus.ifid_en, 0);
    check("lu_idex_en", bus.idex_en, 1);
    check("lu_idex_flush", bus.idex_flush, 1);
    check("lu_ifid_flush", bus.ifid_flush, 0);
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    check("lu_x0_pc_en", bus.pc_en, 1);
    check("lu_x0_idex_flush", bus.idex_flush, 0);
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7;
    bus.id_r2_used = 1'b0;
    #1;
    check("lu_rs2_unused", bus.pc_en, 1);
    bus.id_r2_used = 1'b1;
    #1;
    check("lu_rs2_used", bus.pc_en, 0);

    // 2. Branch overrides load-use
    bus.br_taken = 1'b1;
    #1;
    check("br_pc_en", bus.pc_en, 1);
    check("br_ifid_en", bus.ifid_en, 1);
    check("br_ifid_flush", bus.ifid_flush, 1);
    check("br_idex_flush", bus.idex_flush, 1);
    clr_inputs();
    tick();

    // 3. Simple interrupt entry and uret
    bus.ie = 1'b1;
    bus.irq = 3'b010;
    #1;
    check("e3_a_int_enter", bus.int_enter, 0);
    tick();
    bus.irq = '0;
    #1;
    check("e3_b_int_enter", bus.int_enter, 0);
    tick();
    check("e3_enter", bus.int_enter, 1);
    check("e3_enter_ifid_flush", bus.ifid_flush, 1);
    check("e3_enter_idex_flush", bus.idex_flush, 0);
    check("e3_enter_pc_en", bus.pc_en, 1);
    tick();
    check("e3_isr_int_enter", bus.int_enter, 0);
    check("e3_isr_irs", bus.irs, 3'b010);
    check("e3_isr_busy", bus.int_busy, 1);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("e3_ret_busy", bus.int_busy, 0);
    check("e3_ret_irs", bus.irs, 0);

    // 4. Priority plus retry on br_taken during ENTER
    bus.irq = 3'b011;
    tick();
    bus.irq = '0;
    tick();
    bus.br_taken = 1'b1;
    #1;
    check("e4_retry_int_enter", bus.int_enter, 0);
    check("e4_retry_ifid_flush", bus.ifid_flush, 1);
    tick();
    bus.br_taken = 1'b0;
    #1;
    check("e4_enter", bus.int_enter, 1);
    tick();
    check("e4_isr_irs", bus.irs, 3'b010);
    tick();
    check("e4_wait_int_enter", bus.int_enter, 0);
    check("e4_wait_irs", bus.irs, 3'b010);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("e4_run_busy", bus.int_busy, 0);
    check("e4_run_int_enter", bus.int_enter, 0);
    tick();
    check("e4_enter2", bus.int_enter, 1);
    tick();
    check("e4_isr2_irs", bus.irs, 3'b001);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;

    // 5. Hold freezes everything, pending still latches
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        bus.irq = 3'b100;
        bus.br_taken = 1'b1;
      end
      #1;
      check("h_pc_en", bus.pc_en, 0);
      check("h_idex_en", bus.idex_en, 0);
      check("h_flushes", {bus.ifid_flush, bus.idex_flush}, 0);
      check("h_int_enter", bus.int_enter, 0);
      tick();
      bus.irq = '0;
      bus.br_taken = 1'b0;
    end
    bus.hold = 1'b0;
    #1;
    check("h_rel_pc_en", bus.pc_en, 1);
    check("h_rel_int_enter", bus.int_enter, 0);
    tick();
    check("h_enter", bus.int_enter, 1);
    tick();
    check("h_isr_irs", bus.irs, 3'b100);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;

    // 6. Second request while in ISR for source 0
    bus.irq = 3'b001;
    tick();
    bus.irq = '0;
    tick();
    check("n_enter1", bus.int_enter, 1);
    tick();
    check("n_isr1_irs", bus.irs, 3'b001);
    bus.irq = 3'b100;
    tick();
    bus.irq = '0;
    #1;
    check("n_x_int_enter", bus.int_enter, 0);
    check("n_x_irs", bus.irs, 3'b001);
    tick();
`ifdef INT_NESTED_EN
    check("n_enter2", bus.int_enter, 1);
    check("n_enter2_busy", bus.int_busy, 1);
    tick();
    check("n_isr2_irs", bus.irs, 3'b100);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("n_ret1_irs", bus.irs, 3'b001);
    check("n_ret1_busy", bus.int_busy, 1);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("n_ret2_busy", bus.int_busy, 0);
    check("n_ret2_irs", bus.irs, 0);
`else
    check("s_no_enter2", bus.int_enter, 0);
    check("s_still_irs", bus.irs, 3'b001);
    tick();
    check("s_wait_irs", bus.irs, 3'b001);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("s_ret1_busy", bus.int_busy, 0);
    check("s_ret1_int_enter", bus.int_enter, 0);
    tick();
    check("s_enter2", bus.int_enter, 1);
    tick();
    check("s_isr2_irs", bus.irs, 3'b100);
    bus.uret_ex = 1'b1;
    tick();
    bus.uret_ex = 1'b0;
    #1;
    check("s_ret2_busy", bus.int_busy, 0);
`endif

    // 7. Reset while in ENTER: no bubble, requests lost
    bus.irq = 3'b001;
    tick();
    bus.irq = '0;
    tick();
    rst = 1'b0;
    bus.irq = 3'b010;
    #1;
    check("r_enter_gated", bus.int_enter, 0);
    check("r_ifid_flush", bus.ifid_flush, 0);
    tick();
    rst = 1'b1;
    bus.irq = '0;
    #1;
    check("r_after_int_enter", bus.int_enter, 0);
    check("r_after_busy", bus.int_busy, 0);
    tick();
    check("r_lost_int_enter", bus.int_enter, 0);
    tick();
    check("r_lost2_int_enter", bus.int_enter, 0);

    // 8. ie=0 blocks entry
    bus.ie = 1'b0;
    bus.irq = 3'b010;
    tick();
    bus.irq = '0;
    #1;
    check("ie0_int_enter_a", bus.int_enter, 0);
    tick();
    check("ie0_int_enter_b", bus.int_enter, 0);
    check("ie0_busy", bus.int_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_pipe_ctrl.md
Name: int_pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage interrupt-capable core.
- Generates enable and flush (sync-reset) controls for PC, IF/ID and ID/EX: load-use stall, taken-branch flush, global hold.
- Latches and prioritises external interrupt requests, issues the one-cycle int_enter bubble into ID, and tracks in-service state until uret.

Parameters:
- NUM_IRQ, 3, number of interrupt sources; index NUM_IRQ-1 is highest priority.
- REGW, 5, register-number width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- hold  in  1  global freeze (memory busy / single-step).
- ex_memtoreg  in  1  instruction in EX is a load.
- ex_rd  in  REGW  destination register of the EX instruction.
- id_rs1, id_rs2  in  REGW  source registers of the ID instruction.
- id_r1_used, id_r2_used  in  1  source actually read.
- br_taken  in  1  EX redirect (branch, jump, or Int_Enter bubble).
- uret_ex  in  1  uret in EX.
- ie  in  1  global interrupt enable.
- irq  in  NUM_IRQ  request pulses, one cycle each.
- pc_en, ifid_en, idex_en  out  1  register enables.
- ifid_flush, idex_flush  out  1  sync-reset requests to the bridges.
- int_enter  out  1  converts the ID instruction into the interrupt-entry bubble.
- irs  out  NUM_IRQ  one-hot source being serviced.
- int_busy  out  1  handler active.

Behaviour:
- Reset (rst=0 at a clk edge): pending=0, in_service=0, state=RUN.
  - While rst=0, outputs are: enables 1, flushes 0, int_enter 0, irs 0, int_busy 0.
- load_use = ex_memtoreg & ex_rd!=0 & ((id_r1_used & ex_rd==id_rs1) | (id_r2_used & ex_rd==id_rs2)).
- Pending register:
  - pending <= (pending & ~ack) | irq every cycle, including during hold.
  - Set wins over ack on the same bit in the same cycle.
- FSM states:
  - RUN:
    - If ie & |pending & ~br_taken & ~hold, then next = ENTER.
    - Latch sel = highest-index pending bit; ack = sel.
  - ENTER (exactly one cycle unless retried):
    - If br_taken or hold: int_enter=0, stay in ENTER. The ID instruction is wrong-path or frozen; retry next cycle. sel is kept.
    - Else: int_enter=1, ifid_flush=1, pc_en=ifid_en=idex_en=1; in_service |= sel; next = ISR.
    - load_use is ignored in ENTER, because the ID instruction is replaced by the bubble.
  - ISR:
    - int_busy=1; irs=sel.
    - On uret_ex: clear in_service; next = RUN.
    - uret_ex in RUN or ENTER is ignored.
- Normal control (RUN/ISR, hold=0):
  - pc_en = ifid_en = ~load_use; idex_en = 1.
  - idex_flush = load_use | br_taken.
  - ifid_flush = br_taken.
  - br_taken overrides load_use: enables=1, both flushes=1.
- hold=1:
  - All enables 0, all flushes 0, int_enter 0.
  - FSM frozen; pending still latches.
- ie deasserted mid-ISR does not abort the handler.
- Reset mid-ENTER: no int_enter is issued; all pending requests are lost.
- All comparisons are unsigned, REGW-bit exact.

Optional Feature:
- Macro: INT_NESTED_EN.
- Defined:
  - in_service is a NUM_IRQ-bit mask.
  - In ISR, a pending source whose index is above the highest in_service bit triggers ENTER (same rules as RUN).
  - uret_ex clears the highest in_service bit. Next state is RUN if the mask becomes 0, else ISR, with irs updated to the new highest bit.
- Undefined:
  - Single level. Pending requests wait in ISR until uret.

Decomposition:
- Shared package:
  - state encoding (RUN=2'd0, ENTER=2'd1, ISR=2'd2);
  - NUM_IRQ and REGW defaults;
  - priority_encode function (highest set bit to one-hot).
- One sub-module, hazard_detect: the combinational load_use comparator. The FSM and pending logic stay in the top.

Test Plan:
1. Load-use: ex_memtoreg=1, ex_rd=5, id_rs1=5, id_r1_used=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle. With ex_rd=0 -> no stall.
2. Branch over stall: load_use and br_taken together -> pc_en=1, ifid_flush=1, idex_flush=1.
3. Interrupt entry: ie=1, irq=3'b010 pulse -> ENTER next cycle, int_enter=1 for exactly one cycle, irs=3'b010, int_busy=1. uret_ex -> int_busy=0 next cycle.
4. Priority and retry: irq=3'b011 together, br_taken=1 during ENTER -> int_enter delayed one cycle, serviced irs=3'b010. Bit 0 stays pending and enters after uret.
5. Hold: hold=1 for 4 cycles with irq pulse -> all enables/flushes 0, no int_enter. Entry occurs after hold drops.
6. INT_NESTED_EN: in ISR for source 0, irq=3'b100 -> second int_enter, irs=3'b100. First uret -> irs=3'b001, int_busy=1. Second uret -> RUN. Same stimulus without the macro -> second entry only after the first uret.
